// File: rtl/eep_seq_arb_if.sv
// Bundle of requester-side and EEPROM-side signals for eep_seq_arb.
// slave = the arbiter's view, master = the requesters/EEPROM environment's view.
interface eep_seq_arb_if;
  logic        rd_req0;
  logic [1:0]  addr0;
  logic        rd_req1;
  logic        wr_req1;
  logic [1:0]  addr1;
  logic [13:0] wdata1;
  logic [13:0] eep_rd_data;
  logic        done0;
  logic        done1;
  logic [13:0] rd_data;
  logic        busy;
  logic [1:0]  eep_addr;
  logic [13:0] eep_wr_data;
  logic        eep_cs_n;
  logic        eep_r_w_n;
  logic        chrg_pmp_en;
  logic [1:0]  state_dbg;

  modport slave (
    input  rd_req0, addr0, rd_req1, wr_req1, addr1, wdata1, eep_rd_data,
    output done0, done1, rd_data, busy, eep_addr, eep_wr_data,
           eep_cs_n, eep_r_w_n, chrg_pmp_en, state_dbg
  );

  modport master (
    output rd_req0, addr0, rd_req1, wr_req1, addr1, wdata1, eep_rd_data,
    input  done0, done1, rd_data, busy, eep_addr, eep_wr_data,
           eep_cs_n, eep_r_w_n, chrg_pmp_en, state_dbg
  );
endinterface

// File: rtl/eep_seq_arb.sv
// Round-robin sequencer/arbiter for the shared 4 x 14-bit calibration EEPROM.
// Every output is a register loaded from the next-state decode, so it changes only on clk or reset.
module eep_seq_arb #(
  parameter int RD_CYCLES   = 2,
  parameter int PUMP_CYCLES = 2400000
) (
  input logic         clk,
  input logic         rst_n,
  eep_seq_arb_if.slave bus
);

  // Handshake: each request is a level held until its done pulse; the requester must
  // drop it by the cycle after done, otherwise the following IDLE cycle grants it again.
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [21:0] RD_LAST   = 22'(RD_CYCLES - 1);
  localparam logic [21:0] PUMP_LAST = 22'(PUMP_CYCLES - 1);

  state_t      state, state_nx;
  logic        last_gnt, last_gnt_nx;
  logic [21:0] cnt, cnt_nx;
  logic [1:0]  addr_q, addr_nx;
  logic [13:0] wr_data_q, wr_data_nx;
  logic [13:0] rd_data_q, rd_data_nx;
  logic        cs_n_q, r_w_n_q, pump_q, done0_q, done1_q, busy_q;
  logic        req0, req1, win1;

  assign req0 = bus.rd_req0;
  assign req1 = bus.rd_req1 | bus.wr_req1;

  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    cnt_nx      = cnt;
    addr_nx     = addr_q;
    wr_data_nx  = wr_data_q;
    rd_data_nx  = rd_data_q;
    win1        = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the requester not served last time wins.
          win1        = req1 && (!req0 || !last_gnt);
          last_gnt_nx = win1;
          cnt_nx      = '0;
          if (win1) begin
            addr_nx = bus.addr1;
            if (bus.wr_req1) begin
              wr_data_nx = bus.wdata1;
              state_nx   = WRITE;
            end else begin
              state_nx = READ;
            end
          end else begin
            addr_nx  = bus.addr0;
            state_nx = READ;
          end
        end
      end
      READ: begin
        cnt_nx = cnt + 22'd1;
        if (cnt == RD_LAST) begin
          rd_data_nx = bus.eep_rd_data;
          state_nx   = DONE;
        end
      end
      WRITE: begin
        cnt_nx = cnt + 22'd1;
        if (cnt == PUMP_LAST) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      cnt       <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      cs_n_q    <= 1'b1;
      r_w_n_q   <= 1'b1;
      pump_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      last_gnt  <= last_gnt_nx;
      cnt       <= cnt_nx;
      addr_q    <= addr_nx;
      wr_data_q <= wr_data_nx;
      rd_data_q <= rd_data_nx;
      cs_n_q    <= !(state_nx == READ || state_nx == WRITE);
      r_w_n_q   <= (state_nx != WRITE);
      pump_q    <= (state_nx == WRITE);
      done0_q   <= (state_nx == DONE) && !last_gnt_nx;
      done1_q   <= (state_nx == DONE) && last_gnt_nx;
      busy_q    <= (state_nx != IDLE);
    end
  end

  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = busy_q;
  assign bus.eep_addr    = addr_q;
  assign bus.eep_wr_data = wr_data_q;
  assign bus.eep_cs_n    = cs_n_q;
  assign bus.eep_r_w_n   = r_w_n_q;
  assign bus.chrg_pmp_en = pump_q;
  assign bus.state_dbg   = state;

endmodule

// File: doc/eep_seq_arb.md
Name: eep_seq_arb

Overview:
- Sequencer and arbiter for the shared 4-word x 14-bit EEPROM used for calibration coefficients.
- Two requesters share the device:
  - Requester 0: the digital core, read-only, used for coefficient fetch.
  - Requester 1: the command path, read or write, driven by cfg_UART commands.
- Generates eep_cs_n, eep_r_w_n, eep_addr, eep_wr_data and chrg_pmp_en with correct access timing.
- Holds the charge pump for the full programming time on writes, and returns read data with a done pulse.

Parameters:
- RD_CYCLES, 2: cycles chip select is held for a read before eep_rd_data is sampled; legal range 1..15.
- PUMP_CYCLES, 2400000: cycles chrg_pmp_en is held during a write (3 ms at 800 MHz); legal range 2..2^22-1.

Ports:
- clk  in  1  system clock, 800 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- rd_req0  in  1  requester 0 read request; level, held until done0.
- addr0  in  2  requester 0 word address.
- rd_req1  in  1  requester 1 read request; level, held until done1.
- wr_req1  in  1  requester 1 write request; level, held until done1.
- addr1  in  2  requester 1 word address.
- wdata1  in  14  requester 1 write data.
- eep_rd_data  in  14  EEPROM read data.
- done0  out  1  one-cycle pulse: requester 0 access complete.
- done1  out  1  one-cycle pulse: requester 1 access complete.
- rd_data  out  14  captured read data for whichever requester was last served.
- busy  out  1  high in any state other than IDLE.
- eep_addr  out  2  EEPROM address.
- eep_wr_data  out  14  EEPROM write data.
- eep_cs_n  out  1  EEPROM chip select, active low.
- eep_r_w_n  out  1  1 = read, 0 = write.
- chrg_pmp_en  out  1  charge pump enable.

Behaviour:
- All outputs are registered. Reset values:
  - done0 = 0, done1 = 0, busy = 0.
  - rd_data = 0, eep_addr = 0, eep_wr_data = 0.
  - eep_cs_n = 1, eep_r_w_n = 1, chrg_pmp_en = 0.
  - Internal: last_gnt = 1, counter = 0, state = IDLE.
- States: IDLE, READ, WRITE, DONE.
- IDLE: arbitration is sampled every cycle.
  - Request 0 is rd_req0. Request 1 is rd_req1 | wr_req1.
  - If only one requester is active, it wins.
  - If both are active, the requester not equal to last_gnt wins (round-robin).
  - On a win: latch the winner into last_gnt, latch its addr into eep_addr, latch wdata1 into eep_wr_data (write only), and clear the counter.
  - Requester 1 with rd_req1 = 1 and wr_req1 = 1 at the same time is treated as a write.
  - Next state is READ or WRITE.
- READ: eep_cs_n = 0, eep_r_w_n = 1.
  - Counter increments each cycle.
  - In the RD_CYCLES-th READ cycle, eep_rd_data is registered into rd_data. Next state is DONE.
- WRITE: eep_cs_n = 0, eep_r_w_n = 0, chrg_pmp_en = 1, eep_wr_data stable.
  - Counter increments each cycle.
  - After exactly PUMP_CYCLES WRITE cycles, next state is DONE.
  - rd_data is not modified by a write.
- DONE: lasts one cycle.
  - eep_cs_n = 1, eep_r_w_n = 1, chrg_pmp_en = 0.
  - done0 or done1 pulses for the served requester.
  - Next state is IDLE.
- Latency and handshake:
  - Request seen in IDLE at cycle N: chip select goes active at N+1.
  - Read: done at N+1+RD_CYCLES.
  - Write: done at N+1+PUMP_CYCLES.
  - A requester must deassert its request no later than the cycle after its done pulse. A request still high in that IDLE cycle is served again.
- eep_addr and eep_wr_data are held from grant until the next grant. Requester inputs are ignored outside IDLE.
- Requests that change or drop mid-access do not abort the access.
- Reset asserted mid-access immediately forces eep_cs_n = 1, eep_r_w_n = 1 and chrg_pmp_en = 0. A partially programmed word is not retried.
- The counter is 22 bits. It never wraps, because it is cleared on every grant.

Test Plan:
- Requester 0 read, RD_CYCLES = 2: rd_req0 = 1 with addr0 = 2 in cycle 0, eep_rd_data = 0x1ABC → eep_cs_n = 0 and eep_r_w_n = 1 in cycles 1-2; done0 pulses in cycle 3; rd_data = 0x1ABC; busy = 0 in cycle 4.
- Requester 1 write, PUMP_CYCLES = 16: wr_req1 = 1, addr1 = 3, wdata1 = 0x2345 → eep_cs_n = 0, eep_r_w_n = 0, chrg_pmp_en = 1 for exactly 16 cycles; eep_wr_data = 0x2345; eep_addr = 3; done1 pulses once; rd_data unchanged.
- Simultaneous rd_req0 and rd_req1 held continuously after reset → grant order 0, 1, 0, 1; done pulses alternate; no cycle with both done0 and done1 high.
- rd_req1 = 1 and wr_req1 = 1 together → a write is performed with chrg_pmp_en = 1 and eep_r_w_n = 0.
- rst_n driven low in the 5th WRITE cycle → chrg_pmp_en = 0 and eep_cs_n = 1 in the same cycle, without waiting for a clock edge; after release, state is IDLE and all outputs are at reset values.
- Requester 0 drops rd_req0 mid-read → the read still completes and done0 pulses at the normal cycle.
